cabac_ctx_init: RTL and testbench
=================================

Name: cabac_ctx_init

Overview:
- CABAC context-initialisation engine. It sits directly downstream of the 64-entry, 16-bit context-init ROMs (one-cycle read latency).
- On a start pulse it walks ROM addresses 0..63 and converts each {slope m, offset n} word into an H.265 context state for the slice QP.
- It writes each 7-bit {valMps, pStateIdx} result into the CABAC context-state memory, then signals completion.

Parameters:
- CTX_NUM, 64, number of ROM entries / contexts processed per run
- ADDR_W, 6, ROM and context-memory address width (clog2 of CTX_NUM)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start_i  input  1  single-cycle request; sampled only in IDLE
- qp_i  input  6  slice QP, unsigned, sampled with start_i
- busy_o  output  1  high from the cycle after acceptance through the done cycle
- done_o  output  1  single-cycle pulse after the last write
- rom_en_o  output  1  ROM read enable (registered)
- rom_addr_o  output  ADDR_W  ROM read address (registered)
- rom_data_i  input  16  ROM word, valid the cycle after rom_en_o; [15:8] is m (signed 8), [7:0] is n (signed 8)
- ctx_we_o  output  1  context-memory write enable (registered)
- ctx_addr_o  output  ADDR_W  context-memory write address (registered)
- ctx_data_o  output  7  {valMps, pStateIdx[5:0]} (registered)

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low.
  - While rst_n=0 at a clk edge, all outputs go to 0, the FSM returns to IDLE, and the counters and pipeline valids clear.
- Reset mid-run: no further rom_en_o, ctx_we_o or done_o after the reset edge; a partially written table is left as is.
- FSM states are IDLE, READ, DRAIN, DONE.
  - IDLE: start_i=1 latches qpc = min(qp_i, 51), clears addr_cnt, and moves to READ. At the same edge rom_en_o=1 and rom_addr_o=0.
  - READ: each cycle rom_en_o=1 with rom_addr_o=addr_cnt. When addr_cnt=CTX_NUM-1, move to DRAIN and drop rom_en_o at the next edge.
  - DRAIN: wait until the 2-stage pipeline is empty, then move to DONE.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- start_i outside IDLE is ignored and has no effect on the running pass.
- Pipeline:
  - valid stage 1 = registered rom_en_o (this is when ROM data is valid); stage 1 also carries the address.
  - Stage 2 registers ctx_we_o, ctx_addr_o and ctx_data_o.
  - The write for entry a is asserted exactly 2 cycles after rom_en_o for entry a.
- Timing, with start accepted in cycle 0:
  - rom_en_o high in cycles 1..64.
  - ctx_we_o high in cycles 3..66; addresses are strictly 0..63, in order, one per cycle, with no gaps.
  - done_o in cycle 67.
  - busy_o high in cycles 1..67.
  - A new start is accepted from cycle 68.
- Arithmetic:
  - prod = m * qpc, signed 14 bit.
  - t = (prod >>> 4) + n: arithmetic shift (floor), sign-extended to 11 bit, no overflow possible.
  - pre = Clip3(1, 126, t).
  - If pre <= 63: valMps=0 and pStateIdx = 63 - pre. Otherwise valMps=1 and pStateIdx = pre - 64.
- X handling:
  - rom_data_i is undefined when rom_en_o was low. It is consumed only when the stage-1 valid is set.
  - ctx_data_o and ctx_addr_o hold 0 whenever ctx_we_o=0.
- qp_i changes during a run have no effect; qpc is frozen until the next accept.

Decomposition:
- Shared package / define file:
  - CABAC_CTX_NUM, CABAC_QP_MAX=51, PRE_MIN=1, PRE_MAX=126, MPS_SPLIT=63.
  - FSM state encodings (IDLE=0, READ=1, DRAIN=2, DONE=3).
  - ROM word field positions (M_MSB=15, M_LSB=8, N_MSB=7, N_LSB=0).
- One sub-module, cabac_ctx_state_calc: combinational (m, n, qpc) -> {valMps, pStateIdx}. It is instantiated once in stage 2 and unit-tested on its own.
- FSM, counter and pipeline registers stay in the top module.

Test Plan:
- Entry 0 ROM word 'hFB30 (m=-5, n=48), QP=32 -> ctx write addr 0, data 7'h19 (pre=38). With QP=22 -> 7'h16 (floor shift: -110>>>4=-7, pre=41).
- Entry 20 word 'h0F30, QP=51 -> 7'h5F (pre=95). Entry 62 word 'h0F20, QP=0 -> 7'h1F (pre=32).
- Clipping via stub ROM:
  - 'h8000 with QP=51 -> 7'h3E (pre clipped to 1).
  - 'h7F7F with QP=51 -> 7'h7E (pre clipped to 126).
  - qp_i=60 gives results identical to QP=51.
- Full pass with start in cycle 0:
  - Exactly 64 writes, addresses 0..63, in cycles 3..66.
  - done_o only in cycle 67.
  - busy_o high in cycles 1..67.
  - No ctx_we_o when the ROM returns X outside enable.
- start_i re-pulsed in cycles 10 and 67 -> ignored, still exactly 64 writes. start_i in cycle 68 -> second pass begins with rom_en_o in cycle 69.
- rst_n=0 in cycle 30 -> all outputs 0 at the next edge, no writes or done afterwards. A start after reset release runs a complete, correct pass.

Source files
------------

// File: rtl/cabac_ctx_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cabac_ctx_init_pkg
//  Description : Shared constants, FSM encodings and ROM field positions for
//                the CABAC context-initialisation engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package cabac_ctx_init_pkg;

    localparam int CABAC_CTX_NUM = 64;
    localparam int CABAC_QP_MAX  = 51;
    localparam int PRE_MIN       = 1;
    localparam int PRE_MAX       = 126;
    localparam int MPS_SPLIT     = 63;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // ROM word layout: {m[7:0], n[7:0]}
    localparam int M_MSB = 15;
    localparam int M_LSB = 8;
    localparam int N_MSB = 7;
    localparam int N_LSB = 0;

    // Slice QP saturated to the largest legal value
    function automatic logic [5:0] clip_qp(input logic [5:0] qp);
        return (qp > 6'(CABAC_QP_MAX)) ? 6'(CABAC_QP_MAX) : qp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cabac_ctx_state_calc.sv
`default_nettype none
// ============================================================================
//  Module      : cabac_ctx_state_calc
//  Description : Combinational H.265 context-state derivation from a
//                {slope m, offset n} pair and the clipped slice QP.
//  Revision    : 1.0 - initial release
// ============================================================================
module cabac_ctx_state_calc
    import cabac_ctx_init_pkg::*;
(
    input  logic signed [7:0] i_m,
    input  logic signed [7:0] i_n,
    input  logic        [5:0] i_qpc,
    output logic        [6:0] o_state
);

    localparam logic signed [10:0] c_pre_min = 11'(PRE_MIN);
    localparam logic signed [10:0] c_pre_max = 11'(PRE_MAX);
    localparam logic        [6:0]  c_split   = 7'(MPS_SPLIT);

    logic signed [13:0] w_prod;
    logic signed [13:0] w_sh;
    logic signed [10:0] w_t;
    logic        [6:0]  w_pre;

    // Linear model in QP, floor shift, clip to [1,126], then split on MPS
    always_comb begin
        w_prod = 14'(i_m) * $signed({8'b0, i_qpc});
        w_sh   = w_prod >>> 4;
        w_t    = 11'(w_sh) + 11'(i_n);
        if (w_t < c_pre_min) begin
            w_pre = 7'(PRE_MIN);
        end else if (w_t > c_pre_max) begin
            w_pre = 7'(PRE_MAX);
        end else begin
            w_pre = w_t[6:0];
        end
        if (w_pre <= c_split) begin
            o_state = {1'b0, 6'(c_split - w_pre)};
        end else begin
            o_state = {1'b1, 6'(w_pre - 7'd64)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/cabac_ctx_init.sv
`default_nettype none
// ============================================================================
//  Module      : cabac_ctx_init
//  Description : Walks the 64-entry context-init ROM, converts each word to a
//                context state for the slice QP and writes it into the
//                CABAC context-state memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module cabac_ctx_init
    import cabac_ctx_init_pkg::*;
#(
    parameter int CTX_NUM = CABAC_CTX_NUM,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [5:0]        qp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              ctx_we_o,
    output logic [ADDR_W-1:0] ctx_addr_o,
    output logic [6:0]        ctx_data_o
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(CTX_NUM - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_last;
    logic [5:0]        r_qpc;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_ctx_we;
    logic [ADDR_W-1:0] r_ctx_addr;
    logic [6:0]        r_ctx_data;
    logic signed [7:0] w_m;
    logic signed [7:0] w_n;
    logic [6:0]        w_state_val;

    assign w_last = (r_rom_addr == c_last_addr);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; drain ends once stage 1 is empty, the final write
    // then lands in the same cycle as the move to DONE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_READ;
                    w_accept    = 1'b1;
                end
            end
            ST_READ: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_s1_valid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ROM request side: enable and address double as the entry counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_qpc      <= '0;
        end else begin
            r_rom_en   <= w_accept | ((r_state == ST_READ) & ~w_last);
            r_rom_addr <= ((r_state == ST_READ) && !w_last) ? r_rom_addr + 1'b1 : '0;
            if (w_accept) begin
                r_qpc <= clip_qp(qp_i);
            end
        end
    end

    // ROM data is only looked at while stage 1 holds a valid request
    assign w_m = r_s1_valid ? rom_data_i[M_MSB:M_LSB] : 8'sd0;
    assign w_n = r_s1_valid ? rom_data_i[N_MSB:N_LSB] : 8'sd0;

    cabac_ctx_state_calc u_calc (
        .i_m     (w_m),
        .i_n     (w_n),
        .i_qpc   (r_qpc),
        .o_state (w_state_val)
    );

    // Two-stage pipeline: stage 1 tracks ROM latency, stage 2 drives the write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_ctx_we   <= 1'b0;
            r_ctx_addr <= '0;
            r_ctx_data <= '0;
        end else begin
            r_s1_valid <= r_rom_en;
            r_s1_addr  <= r_rom_addr;
            r_ctx_we   <= r_s1_valid;
            r_ctx_addr <= r_s1_valid ? r_s1_addr : '0;
            r_ctx_data <= r_s1_valid ? w_state_val : '0;
        end
    end

    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = (r_state == ST_DONE);
    assign rom_en_o   = r_rom_en;
    assign rom_addr_o = r_rom_addr;
    assign ctx_we_o   = r_ctx_we;
    assign ctx_addr_o = r_ctx_addr;
    assign ctx_data_o = r_ctx_data;

endmodule
`default_nettype wire

// File: tb/tb_cabac_ctx_init.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cabac_ctx_init
//  Description : Self-checking bench for cabac_ctx_init and its state-calc
//                sub-module, with a one-cycle-latency stub ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cabac_ctx_init;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [5:0]  qp_i;
    logic        busy_o;
    logic        done_o;
    logic        rom_en_o;
    logic [5:0]  rom_addr_o;
    logic [15:0] rom_data_i;
    logic        ctx_we_o;
    logic [5:0]  ctx_addr_o;
    logic [6:0]  ctx_data_o;

    logic signed [7:0] u_m;
    logic signed [7:0] u_n;
    logic [5:0]        u_qpc;
    logic [6:0]        u_state;

    logic [15:0] rom [64];
    logic [6:0]  cap [64];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    cabac_ctx_init #(.CTX_NUM(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .qp_i       (qp_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rom_en_o   (rom_en_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .ctx_we_o   (ctx_we_o),
        .ctx_addr_o (ctx_addr_o),
        .ctx_data_o (ctx_data_o)
    );

    cabac_ctx_state_calc u_calc (
        .i_m     (u_m),
        .i_n     (u_n),
        .i_qpc   (u_qpc),
        .o_state (u_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub ROM: registered read, garbage whenever not enabled
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom[rom_addr_o];
        else          rom_data_i <= 16'($urandom);
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    // Reference context state computed with plain integer arithmetic
    function automatic logic [6:0] model(input logic [15:0] w, input int qp);
        int m, n, q, prod, sh, t, pre;
        m    = (w[15:8] >= 8'h80) ? int'(w[15:8]) - 256 : int'(w[15:8]);
        n    = (w[7:0]  >= 8'h80) ? int'(w[7:0])  - 256 : int'(w[7:0]);
        q    = (qp > 51) ? 51 : qp;
        prod = m * q;
        sh   = (prod >= 0) ? prod / 16 : -((-prod + 15) / 16);
        t    = sh + n;
        pre  = (t < 1) ? 1 : ((t > 126) ? 126 : t);
        if (pre <= 63) return 7'(63 - pre);
        else           return 7'(64 + (pre - 64));
    endfunction

    // One pass starting at the next falling edge; k counts cycles after accept
    task automatic run_pass(input int qp, input bit ign, input int rst_at, input int len);
        bit act;
        for (int i = 0; i < 64; i++) cap[i] = 7'h7F;
        @(negedge clk);
        start_i = 1'b1;
        qp_i    = 6'(qp);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            qp_i    = 6'(k);
            act     = (rst_at == 0) || (k <= rst_at);
            chk("rom_en",  k, 32'(rom_en_o), 32'(act && k <= 64));
            chk("busy",    k, 32'(busy_o),   32'(act && k <= 67));
            chk("done",    k, 32'(done_o),   32'(act && k == 67));
            chk("ctx_we",  k, 32'(ctx_we_o), 32'(act && k >= 3 && k <= 66));
            if (act && k <= 64) chk("rom_addr", k, 32'(rom_addr_o), 32'(k - 1));
            if (act && k >= 3 && k <= 66) begin
                chk("ctx_addr", k, 32'(ctx_addr_o), 32'(k - 3));
                chk("ctx_data", k, 32'(ctx_data_o), 32'(model(rom[k-3], qp)));
                cap[k-3] = ctx_data_o;
            end else begin
                chk("ctx_addr_idle", k, 32'(ctx_addr_o), 32'd0);
                chk("ctx_data_idle", k, 32'(ctx_data_o), 32'd0);
            end
            if (ign && (k == 10 || k == 67)) start_i = 1'b1;
            if (rst_at != 0 && k == rst_at)     rst_n = 1'b0;
            if (rst_at != 0 && k == rst_at + 1) rst_n = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] m;
        logic [7:0] n;
        logic [5:0] qpc;
        logic [6:0] exp;
    } unit_vec_t;

    typedef struct {
        int         qp;
        bit         ign;
        int         rst_at;
        int         len;
        int         ia;
        logic [6:0] ea;
        int         ib;
        logic [6:0] eb;
    } pass_vec_t;

    unit_vec_t uv [12];
    pass_vec_t pv [6];

    initial begin
        // Hand-computed state-calc vectors
        uv[0]  = '{8'hFB, 8'h30, 6'd32, 7'h19};
        uv[1]  = '{8'hFB, 8'h30, 6'd22, 7'h16};
        uv[2]  = '{8'h0F, 8'h30, 6'd51, 7'h5F};
        uv[3]  = '{8'h0F, 8'h20, 6'd0,  7'h1F};
        uv[4]  = '{8'h80, 8'h00, 6'd51, 7'h3E};
        uv[5]  = '{8'h7F, 8'h7F, 6'd51, 7'h7E};
        uv[6]  = '{8'h00, 8'h3F, 6'd0,  7'h00};
        uv[7]  = '{8'h00, 8'h40, 6'd0,  7'h40};
        uv[8]  = '{8'h00, 8'h00, 6'd0,  7'h3E};
        uv[9]  = '{8'h00, 8'h7F, 6'd0,  7'h7E};
        uv[10] = '{8'hFF, 8'h00, 6'd1,  7'h3E};
        uv[11] = '{8'h01, 8'h3F, 6'd16, 7'h40};

        // Passes: {qp, ignored starts, reset cycle, length, two spot checks}
        pv[0] = '{32, 1'b0, 0,  72, 0,  7'h19, 2, 7'h7E};
        pv[1] = '{22, 1'b0, 0,  72, 0,  7'h16, 1, 7'h3E};
        pv[2] = '{51, 1'b1, 0,  67, 20, 7'h5F, 1, 7'h3E};
        pv[3] = '{0,  1'b0, 0,  72, 62, 7'h1F, 1, 7'h3E};
        pv[4] = '{60, 1'b0, 30, 72, -1, 7'h00, -1, 7'h00};
        pv[5] = '{60, 1'b0, 0,  72, 20, 7'h5F, 2, 7'h7E};

        for (int a = 0; a < 64; a++) rom[a] = {8'(a * 5 - 160), 8'(a * 11)};
        rom[0]  = 16'hFB30;
        rom[1]  = 16'h8000;
        rom[2]  = 16'h7F7F;
        rom[20] = 16'h0F30;
        rom[62] = 16'h0F20;

        rst_n   = 1'b0;
        start_i = 1'b0;
        qp_i    = 6'd0;
        u_m     = '0;
        u_n     = '0;
        u_qpc   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   0, 32'(busy_o),     32'd0);
        chk("rst_done",   0, 32'(done_o),     32'd0);
        chk("rst_rom_en", 0, 32'(rom_en_o),   32'd0);
        chk("rst_ctx_we", 0, 32'(ctx_we_o),   32'd0);
        chk("rst_data",   0, 32'(ctx_data_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            u_m   = uv[i].m;
            u_n   = uv[i].n;
            u_qpc = uv[i].qpc;
            #1;
            chk("calc", i, 32'(u_state), 32'(uv[i].exp));
        end

        for (int p = 0; p < 6; p++) begin
            run_pass(pv[p].qp, pv[p].ign, pv[p].rst_at, pv[p].len);
            if (pv[p].ia >= 0) chk("spot_a", p, 32'(cap[pv[p].ia]), 32'(pv[p].ea));
            if (pv[p].ib >= 0) chk("spot_b", p, 32'(cap[pv[p].ib]), 32'(pv[p].eb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
